// File: rtl/rf_mport_scoreboard_if.sv
// rf_mport_scoreboard_if: read/write/issue/debug bundle of the register file scoreboard
interface rf_mport_scoreboard_if #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRD = 2
);
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              we0;
  logic [AW-1:0]     wa0;
  logic [DW-1:0]     wd0;
  logic              we1;
  logic [AW-1:0]     wa1;
  logic [DW-1:0]     wd1;
  logic              iss_valid;
  logic [AW-1:0]     iss_addr;
  logic [AW-1:0]     dbg_addr;
  logic [DW-1:0]     dbg_data;
  logic [AW:0]       busy_cnt;
  modport master (
    output rd_addr, we0, wa0, wd0, we1, wa1, wd1, iss_valid, iss_addr, dbg_addr,
    input  rd_data, rd_busy, dbg_data, busy_cnt
  );
  modport slave (
    input  rd_addr, we0, wa0, wd0, we1, wa1, wd1, iss_valid, iss_addr, dbg_addr,
    output rd_data, rd_busy, dbg_data, busy_cnt
  );
endinterface

// File: rtl/rf_mport_scoreboard.sv
// rf_mport_scoreboard: multi-read dual-write register file with write bypass and busy scoreboard
module rf_mport_scoreboard #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input logic clk,
  input logic rst,
  rf_mport_scoreboard_if.slave bus
);
  localparam int DEPTH = 1 << AW;
  logic [DW-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy, set_v, clr_v;
  logic [NRD-1:0][DW-1:0] rdd;
  logic [NRD-1:0] rdb;
  logic [AW:0] cnt;
  function automatic logic zr(input logic [AW-1:0] a);
    return ZERO_REG != 0 && a == '0;
  endfunction
  for (genvar e = 0; e < DEPTH; e++) begin : g_e
    assign set_v[e] = bus.iss_valid && bus.iss_addr == AW'(e) && !zr(AW'(e));
    assign clr_v[e] = (bus.we0 && bus.wa0 == AW'(e)) || (bus.we1 && bus.wa1 == AW'(e));
  end
  // port 1 is written last so it wins an address collision
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      busy <= set_v | (busy & ~clr_v);
      if (bus.we0 && !zr(bus.wa0)) mem[bus.wa0] <= bus.wd0;
      if (bus.we1 && !zr(bus.wa1)) mem[bus.wa1] <= bus.wd1;
    end
  // a same-cycle writeback resolves the hazard since its data is bypassed
  for (genvar k = 0; k < NRD; k++) begin : g_k
    logic [AW-1:0] a;
    assign a = bus.rd_addr[k*AW +: AW];
    assign rdd[k] = rst || zr(a) ? '0 :
                    bus.we1 && bus.wa1 == a ? bus.wd1 :
                    bus.we0 && bus.wa0 == a ? bus.wd0 : mem[a];
    assign rdb[k] = !rst && !zr(a) && busy[a] && !clr_v[a];
  end
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + (AW+1)'(busy[i]);
  end
  assign bus.rd_data  = rdd;
  assign bus.rd_busy  = rdb;
  assign bus.dbg_data = rst || zr(bus.dbg_addr) ? '0 : mem[bus.dbg_addr];
  assign bus.busy_cnt = rst ? '0 : cnt;
endmodule

// File: tb/tb_rf_mport_scoreboard.sv
// tb_rf_mport_scoreboard: directed and model-checked tests of the register file scoreboard
module tb_rf_mport_scoreboard;
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int errs = 0;
  logic [31:0] m [32];
  logic mb [32];
  rf_mport_scoreboard_if #(.DW(32), .AW(5), .NRD(2)) bus ();
  rf_mport_scoreboard_if #(.DW(32), .AW(5), .NRD(2)) bus_z ();
  rf_mport_scoreboard #(.DW(32), .AW(5), .NRD(2), .ZERO_REG(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  rf_mport_scoreboard #(.DW(32), .AW(5), .NRD(2), .ZERO_REG(0)) dut_z (.clk(clk), .rst(rst), .bus(bus_z));
  assign bus_z.rd_addr   = bus.rd_addr;
  assign bus_z.we0       = bus.we0;
  assign bus_z.wa0       = bus.wa0;
  assign bus_z.wd0       = bus.wd0;
  assign bus_z.we1       = bus.we1;
  assign bus_z.wa1       = bus.wa1;
  assign bus_z.wd1       = bus.wd1;
  assign bus_z.iss_valid = bus.iss_valid;
  assign bus_z.iss_addr  = bus.iss_addr;
  assign bus_z.dbg_addr  = bus.dbg_addr;
  always #5 clk = ~clk;
  task automatic idle();
    bus.we0 = 0; bus.wa0 = 0; bus.wd0 = 0;
    bus.we1 = 0; bus.wa1 = 0; bus.wd1 = 0;
    bus.iss_valid = 0; bus.iss_addr = 0;
  endtask
  task automatic test_reset();
    bus.we0 = 1; bus.wa0 = 5; bus.wd0 = 32'h1234;
    bus.iss_valid = 1; bus.iss_addr = 5;
    @(posedge clk); #1;
    idle(); bus.rd_addr = {5'd0, 5'd5}; bus.dbg_addr = 5;
    #1;
    vectors++; if (bus.rd_data[31:0] !== 32'h1234) begin errs++; $display("FAIL reset_preload_data got %h exp %h", bus.rd_data[31:0], 32'h1234); end
    vectors++; if (bus.rd_busy[0] !== 1'b1) begin errs++; $display("FAIL reset_preload_busy got %b exp 1", bus.rd_busy[0]); end
    vectors++; if (bus.busy_cnt !== 6'd1) begin errs++; $display("FAIL reset_preload_cnt got %0d exp 1", bus.busy_cnt); end
    #1 rst = 1;
    bus.we1 = 1; bus.wa1 = 5; bus.wd1 = 32'hFFFF;
    #1;
    vectors++; if (bus.rd_data[31:0] !== 32'h0) begin errs++; $display("FAIL reset_async_data got %h exp 0", bus.rd_data[31:0]); end
    vectors++; if (bus.rd_busy !== 2'b00) begin errs++; $display("FAIL reset_async_busy got %b exp 00", bus.rd_busy); end
    vectors++; if (bus.busy_cnt !== 6'd0) begin errs++; $display("FAIL reset_async_cnt got %0d exp 0", bus.busy_cnt); end
    vectors++; if (bus.dbg_data !== 32'h0) begin errs++; $display("FAIL reset_async_dbg got %h exp 0", bus.dbg_data); end
    @(posedge clk); #1;
    rst = 0; idle();
    #1;
    vectors++; if (bus.dbg_data !== 32'h0) begin errs++; $display("FAIL reset_write_dropped got %h exp 0", bus.dbg_data); end
    vectors++; if (bus.busy_cnt !== 6'd0) begin errs++; $display("FAIL reset_cnt_after got %0d exp 0", bus.busy_cnt); end
  endtask
  task automatic test_zero_reg();
    @(posedge clk); #1;
    bus.we0 = 1; bus.wa0 = 0; bus.wd0 = 32'hDEADBEEF;
    bus.iss_valid = 1; bus.iss_addr = 0;
    bus.rd_addr = {5'd0, 5'd0}; bus.dbg_addr = 0;
    #1;
    vectors++; if (bus.rd_data[31:0] !== 32'h0) begin errs++; $display("FAIL zero_bypass got %h exp 0", bus.rd_data[31:0]); end
    vectors++; if (bus_z.rd_data[31:0] !== 32'hDEADBEEF) begin errs++; $display("FAIL zero_off_bypass got %h exp deadbeef", bus_z.rd_data[31:0]); end
    @(posedge clk); #1;
    idle();
    #1;
    vectors++; if (bus.busy_cnt !== 6'd0) begin errs++; $display("FAIL zero_cnt got %0d exp 0", bus.busy_cnt); end
    vectors++; if (bus.dbg_data !== 32'h0) begin errs++; $display("FAIL zero_dbg got %h exp 0", bus.dbg_data); end
    vectors++; if (bus.rd_busy[0] !== 1'b0) begin errs++; $display("FAIL zero_busy got %b exp 0", bus.rd_busy[0]); end
    vectors++; if (bus_z.dbg_data !== 32'hDEADBEEF) begin errs++; $display("FAIL zero_off_dbg got %h exp deadbeef", bus_z.dbg_data); end
    vectors++; if (bus_z.busy_cnt !== 6'd1) begin errs++; $display("FAIL zero_off_cnt got %0d exp 1", bus_z.busy_cnt); end
  endtask
  task automatic test_bypass();
    bus.we0 = 1; bus.wa0 = 7; bus.wd0 = 32'hAAAA;
    bus.we1 = 1; bus.wa1 = 7; bus.wd1 = 32'h5555;
    bus.rd_addr = {5'd7, 5'd8};
    #1;
    vectors++; if (bus.rd_data[63:32] !== 32'h5555) begin errs++; $display("FAIL bypass_prio got %h exp 5555", bus.rd_data[63:32]); end
    vectors++; if (bus.rd_data[31:0] !== 32'h0) begin errs++; $display("FAIL bypass_other got %h exp 0", bus.rd_data[31:0]); end
    @(posedge clk); #1;
    idle(); bus.dbg_addr = 7;
    bus.we0 = 1; bus.wa0 = 8; bus.wd0 = 32'hCAFE;
    #1;
    vectors++; if (bus.dbg_data !== 32'h5555) begin errs++; $display("FAIL bypass_dbg got %h exp 5555", bus.dbg_data); end
    vectors++; if (bus.rd_data[63:32] !== 32'h5555) begin errs++; $display("FAIL bypass_stored got %h exp 5555", bus.rd_data[63:32]); end
    vectors++; if (bus.rd_data[31:0] !== 32'hCAFE) begin errs++; $display("FAIL bypass_we0 got %h exp cafe", bus.rd_data[31:0]); end
    bus.dbg_addr = 8;
    #1;
    vectors++; if (bus.dbg_data !== 32'h0) begin errs++; $display("FAIL bypass_dbg_nobypass got %h exp 0", bus.dbg_data); end
    @(posedge clk); #1;
    idle();
    #1;
    vectors++; if (bus.dbg_data !== 32'hCAFE) begin errs++; $display("FAIL bypass_we0_commit got %h exp cafe", bus.dbg_data); end
  endtask
  task automatic test_scoreboard();
    bus.iss_valid = 1; bus.iss_addr = 9;
    @(posedge clk); #1;
    idle(); bus.rd_addr = {5'd8, 5'd9};
    #1;
    vectors++; if (bus.rd_busy !== 2'b01) begin errs++; $display("FAIL sb_busy got %b exp 01", bus.rd_busy); end
    vectors++; if (bus.busy_cnt !== 6'd1) begin errs++; $display("FAIL sb_cnt got %0d exp 1", bus.busy_cnt); end
    bus.we0 = 1; bus.wa0 = 9; bus.wd0 = 32'h42;
    #1;
    vectors++; if (bus.rd_busy[0] !== 1'b0) begin errs++; $display("FAIL sb_wb_busy got %b exp 0", bus.rd_busy[0]); end
    vectors++; if (bus.rd_data[31:0] !== 32'h42) begin errs++; $display("FAIL sb_wb_data got %h exp 42", bus.rd_data[31:0]); end
    vectors++; if (bus.busy_cnt !== 6'd1) begin errs++; $display("FAIL sb_wb_cnt_pre got %0d exp 1", bus.busy_cnt); end
    @(posedge clk); #1;
    idle();
    #1;
    vectors++; if (bus.busy_cnt !== 6'd0) begin errs++; $display("FAIL sb_wb_cnt_post got %0d exp 0", bus.busy_cnt); end
    vectors++; if (bus.rd_data[31:0] !== 32'h42) begin errs++; $display("FAIL sb_wb_stored got %h exp 42", bus.rd_data[31:0]); end
  endtask
  task automatic test_collision();
    bus.iss_valid = 1; bus.iss_addr = 3;
    @(posedge clk); #1;
    bus.we1 = 1; bus.wa1 = 3; bus.wd1 = 32'h77;
    @(posedge clk); #1;
    idle(); bus.rd_addr = {5'd0, 5'd3};
    #1;
    vectors++; if (bus.rd_busy[0] !== 1'b1) begin errs++; $display("FAIL coll_busy got %b exp 1", bus.rd_busy[0]); end
    vectors++; if (bus.rd_data[31:0] !== 32'h77) begin errs++; $display("FAIL coll_data got %h exp 77", bus.rd_data[31:0]); end
    vectors++; if (bus.busy_cnt !== 6'd1) begin errs++; $display("FAIL coll_cnt got %0d exp 1", bus.busy_cnt); end
    bus.iss_valid = 1; bus.iss_addr = 3;
    @(posedge clk); #1;
    idle();
    #1;
    vectors++; if (bus.busy_cnt !== 6'd1) begin errs++; $display("FAIL coll_reissue_cnt got %0d exp 1", bus.busy_cnt); end
    bus.we1 = 1; bus.wa1 = 3; bus.wd1 = 32'h78;
    @(posedge clk); #1;
    idle();
    #1;
    vectors++; if (bus.busy_cnt !== 6'd0) begin errs++; $display("FAIL coll_clear_cnt got %0d exp 0", bus.busy_cnt); end
    vectors++; if (bus.rd_data[31:0] !== 32'h78) begin errs++; $display("FAIL coll_clear_data got %h exp 78", bus.rd_data[31:0]); end
  endtask
  task automatic test_fill_random();
    logic [4:0] a;
    logic [31:0] ed;
    logic eb, s, c;
    int n;
    #1 rst = 1;
    #1 rst = 0;
    for (int i = 0; i < 32; i++) begin m[i] = 0; mb[i] = (i != 0); end
    for (int i = 1; i < 32; i++) begin
      bus.iss_valid = 1; bus.iss_addr = 5'(i);
      @(posedge clk); #1;
    end
    bus.iss_addr = 0;
    @(posedge clk); #1;
    idle();
    #1;
    vectors++; if (bus.busy_cnt !== 6'd31) begin errs++; $display("FAIL fill_cnt got %0d exp 31", bus.busy_cnt); end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      bus.we0 = 1'($urandom); bus.wa0 = 5'($urandom); bus.wd0 = $urandom;
      bus.we1 = 1'($urandom); bus.wa1 = 5'($urandom); bus.wd1 = $urandom;
      bus.iss_valid = 1'($urandom); bus.iss_addr = 5'($urandom);
      bus.rd_addr = 10'($urandom); bus.dbg_addr = 5'($urandom);
      #1;
      for (int k = 0; k < 2; k++) begin
        a = bus.rd_addr[k*5 +: 5];
        c = (bus.we0 && bus.wa0 == a) || (bus.we1 && bus.wa1 == a);
        ed = (a == 0) ? 32'h0 : (bus.we1 && bus.wa1 == a) ? bus.wd1 : (bus.we0 && bus.wa0 == a) ? bus.wd0 : m[a];
        eb = (a != 0) && mb[a] && !c;
        vectors++; if (bus.rd_data[k*32 +: 32] !== ed) begin errs++; $display("FAIL rnd_data cyc %0d port %0d got %h exp %h", cyc, k, bus.rd_data[k*32 +: 32], ed); end
        vectors++; if (bus.rd_busy[k] !== eb) begin errs++; $display("FAIL rnd_busy cyc %0d port %0d got %b exp %b", cyc, k, bus.rd_busy[k], eb); end
      end
      ed = (bus.dbg_addr == 0) ? 32'h0 : m[bus.dbg_addr];
      vectors++; if (bus.dbg_data !== ed) begin errs++; $display("FAIL rnd_dbg cyc %0d got %h exp %h", cyc, bus.dbg_data, ed); end
      n = 0;
      for (int e = 0; e < 32; e++) n += int'(mb[e]);
      vectors++; if (bus.busy_cnt !== 6'(n)) begin errs++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", cyc, bus.busy_cnt, n); end
      for (int e = 1; e < 32; e++) begin
        s = bus.iss_valid && bus.iss_addr == 5'(e);
        c = (bus.we0 && bus.wa0 == 5'(e)) || (bus.we1 && bus.wa1 == 5'(e));
        mb[e] = s ? 1'b1 : c ? 1'b0 : mb[e];
      end
      if (bus.we0 && bus.wa0 != 0) m[bus.wa0] = bus.wd0;
      if (bus.we1 && bus.wa1 != 0) m[bus.wa1] = bus.wd1;
      @(posedge clk); #1;
    end
    idle();
  endtask
  initial begin
    rst = 1; idle(); bus.rd_addr = 0; bus.dbg_addr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    test_reset();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_collision();
    test_fill_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
